uart_cmd_bridge: RTL

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

---
 rtl/uart_cmd_bridge.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge
//   Turns framed command bytes received over a UART into single-cycle
//   read/write requests towards the rc, and returns the result over the UART
//   transmitter ('K' for a posted write, four read-data bytes MSB first for
//   a read).
//
//   Frame: 'R' (0x52) + addr[31:0] MSB first
//          'W' (0x57) + addr[31:0] MSB first + data[31:0] MSB first
//
// Ports
//   QClk / RstQnnnH               clock, asynchronous active-low reset
//   RxByteValid / RxByte          received byte strobe and value
//   C2F_Req*Q500H                 registered request, ReqValid is a 1-cycle pulse
//   C2F_Rsp*Q502H                 response from rc (only RD_RSP on THREAD_ID used)
//   C2F_RspStall                  rc cannot take a request this cycle
//   TxByteValid / TxByte          byte offered to the transmitter (held until ready)
//   TxByteReady                   transmitter accepts the offered byte
//   FrameErr                      1-cycle pulse on any framing fault

package uart_cmd_bridge_pkg;
    typedef enum logic [1:0] {
        RD     = 2'b00,
        WR     = 2'b01,
        RD_RSP = 2'b10,
        WR_RSP = 2'b11
    } t_opcode;
endpackage

module uart_cmd_bridge
    import uart_cmd_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [1:0]  THREAD_ID      = 2'b00
) (
    input  logic        QClk,
    input  logic        RstQnnnH,
    input  logic        RxByteValid,
    input  logic [7:0]  RxByte,
    output logic        C2F_ReqValidQ500H,
    output t_opcode     C2F_ReqOpcodeQ500H,
    output logic [1:0]  C2F_ReqThreadIDQ500H,
    output logic [31:0] C2F_ReqAddressQ500H,
    output logic [31:0] C2F_ReqDataQ500H,
    input  logic        C2F_RspValidQ502H,
    input  t_opcode     C2F_RspOpcodeQ502H,
    input  logic [1:0]  C2F_RspThreadIDQ502H,
    input  logic [31:0] C2F_RspDataQ502H,
    input  logic        C2F_RspStall,
    output logic        TxByteValid,
    output logic [7:0]  TxByte,
    input  logic        TxByteReady,
    output logic        FrameErr
);

    localparam int unsigned          TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]           CMD_RD     = 8'h52;
    localparam logic [7:0]           CMD_WR     = 8'h57;
    localparam logic [7:0]           ACK_BYTE   = 8'h4B;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_DATA     = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_RSP = 3'd4,
        S_SEND     = 3'd5
    } t_state;

    t_state             state_r,    state_s;
    logic               isWrite_r,  isWrite_s;
    logic [1:0]         byteCnt_r,  byteCnt_s;
    logic [31:0]        addr_r,     addr_s;
    logic [31:0]        data_r,     data_s;
    logic [TIMER_W-1:0] timer_r,    timer_s;
    logic [23:0]        txShift_r,  txShift_s;   // read-data bytes still to send
    logic [1:0]         txLeft_r,   txLeft_s;    // bytes remaining after TxByte
    logic               reqValid_r, reqValid_s;
    t_opcode            reqOp_r,    reqOp_s;
    logic [1:0]         reqThr_r,   reqThr_s;
    logic [31:0]        reqAddr_r,  reqAddr_s;
    logic [31:0]        reqData_r,  reqData_s;
    logic               txValid_r,  txValid_s;
    logic [7:0]         txByte_r,   txByte_s;
    logic               frameErr_r, frameErr_s;
    logic               issueNow_s;

    // Next-state and next-register computation for the frame FSM.
    always_comb begin
        state_s    = state_r;
        isWrite_s  = isWrite_r;
        byteCnt_s  = byteCnt_r;
        addr_s     = addr_r;
        data_s     = data_r;
        timer_s    = timer_r;
        txShift_s  = txShift_r;
        txLeft_s   = txLeft_r;
        reqValid_s = 1'b0;
        reqOp_s    = reqOp_r;
        reqThr_s   = reqThr_r;
        reqAddr_s  = reqAddr_r;
        reqData_s  = reqData_r;
        txValid_s  = txValid_r;
        txByte_s   = txByte_r;
        frameErr_s = 1'b0;
        issueNow_s = 1'b0;

        case (state_r)
            S_IDLE: begin
                timer_s = '0;
                if (RxByteValid) begin
                    if ((RxByte == CMD_RD) || (RxByte == CMD_WR)) begin
                        isWrite_s = (RxByte == CMD_WR);
                        byteCnt_s = 2'd0;
                        addr_s    = 32'h0;
                        data_s    = 32'h0;
                        state_s   = S_ADDR;
                    end else begin
                        frameErr_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADDR, S_DATA: begin
                if (RxByteValid) begin
                    timer_s   = '0;
                    byteCnt_s = byteCnt_r + 2'd1;
                    if (state_r == S_ADDR) begin
                        addr_s = {addr_r[23:0], RxByte};
                    end else begin
                        data_s = {data_r[23:0], RxByte};
                    end
                    if (byteCnt_r == 2'd3) begin
                        if ((state_r == S_ADDR) && isWrite_r) begin
                            state_s = S_DATA;
                        end else begin
                            // Issue straight away when the rc is free so the
                            // request lands the cycle after the last byte.
                            state_s    = S_ISSUE;
                            issueNow_s = ~C2F_RspStall;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    frameErr_s = 1'b1;
                    timer_s    = '0;
                    state_s    = S_IDLE;
                end else begin
                    timer_s = timer_r + TIMER_W'(1);
                end
            end
            S_ISSUE: begin
                frameErr_s = RxByteValid;
                issueNow_s = ~C2F_RspStall;
            end
            S_WAIT_RSP: begin
                frameErr_s = RxByteValid;
                if (C2F_RspValidQ502H && (C2F_RspOpcodeQ502H == RD_RSP) &&
                    (C2F_RspThreadIDQ502H == THREAD_ID)) begin
                    txShift_s = C2F_RspDataQ502H[23:0];
                    txByte_s  = C2F_RspDataQ502H[31:24];
                    txValid_s = 1'b1;
                    txLeft_s  = 2'd3;
                    state_s   = S_SEND;
                end else begin
                    state_s = S_WAIT_RSP;
                end
            end
            S_SEND: begin
                frameErr_s = RxByteValid;
                if (txValid_r && TxByteReady) begin
                    if (txLeft_r == 2'd0) begin
                        txValid_s = 1'b0;
                        txByte_s  = 8'h00;
                        state_s   = S_IDLE;
                    end else begin
                        txByte_s  = txShift_r[23:16];
                        txShift_s = {txShift_r[15:0], 8'h00};
                        txLeft_s  = txLeft_r - 2'd1;
                    end
                end else begin
                    state_s = S_SEND;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        // Request launch; a write is posted and acknowledged immediately.
        if (issueNow_s) begin
            reqValid_s = 1'b1;
            reqThr_s   = THREAD_ID;
            reqAddr_s  = addr_s;
            if (isWrite_r) begin
                reqOp_s   = WR;
                reqData_s = data_s;
                txByte_s  = ACK_BYTE;
                txValid_s = 1'b1;
                txLeft_s  = 2'd0;
                state_s   = S_SEND;
            end else begin
                reqOp_s   = RD;
                reqData_s = 32'h0;
                state_s   = S_WAIT_RSP;
            end
        end else begin
            reqThr_s = reqThr_r;
        end
    end

    // FSM state register.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            isWrite_r  <= 1'b0;
            byteCnt_r  <= 2'd0;
            addr_r     <= 32'h0;
            data_r     <= 32'h0;
            timer_r    <= '0;
            txShift_r  <= 24'h0;
            txLeft_r   <= 2'd0;
            reqValid_r <= 1'b0;
            reqOp_r    <= RD;
            reqThr_r   <= 2'b00;
            reqAddr_r  <= 32'h0;
            reqData_r  <= 32'h0;
            txValid_r  <= 1'b0;
            txByte_r   <= 8'h00;
            frameErr_r <= 1'b0;
        end else begin
            isWrite_r  <= isWrite_s;
            byteCnt_r  <= byteCnt_s;
            addr_r     <= addr_s;
            data_r     <= data_s;
            timer_r    <= timer_s;
            txShift_r  <= txShift_s;
            txLeft_r   <= txLeft_s;
            reqValid_r <= reqValid_s;
            reqOp_r    <= reqOp_s;
            reqThr_r   <= reqThr_s;
            reqAddr_r  <= reqAddr_s;
            reqData_r  <= reqData_s;
            txValid_r  <= txValid_s;
            txByte_r   <= txByte_s;
            frameErr_r <= frameErr_s;
        end
    end

    assign C2F_ReqValidQ500H    = reqValid_r;
    assign C2F_ReqOpcodeQ500H   = reqOp_r;
    assign C2F_ReqThreadIDQ500H = reqThr_r;
    assign C2F_ReqAddressQ500H  = reqAddr_r;
    assign C2F_ReqDataQ500H     = reqData_r;
    assign TxByteValid          = txValid_r;
    assign TxByte               = txByte_r;
    assign FrameErr             = frameErr_r;

endmodule
